// File: rtl/calc1_pkg.sv
// Shared widths, command/response encodings and channel state for the calc1 calculator.
package calc1_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned CMD_W   = 4;
  localparam int unsigned RESP_W  = 2;
  localparam int unsigned SHAMT_W = $clog2(DATA_W);

  typedef enum logic [CMD_W-1:0] {
    NOP = 4'd0,
    ADD = 4'd1,
    SUB = 4'd2,
    SHL = 4'd5,
    SHR = 4'd6
  } cmd_e;

  typedef enum logic [RESP_W-1:0] {
    NONE = 2'b00,
    OK   = 2'b01,
    OVF  = 2'b10,
    BAD  = 2'b11
  } resp_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OP2  = 2'd1,
    EXEC = 2'd2
  } chan_state_e;

  // Response payload as registered on the output of a channel
  typedef struct packed {
    resp_e             resp;
    logic [DATA_W-1:0] data;
  } resp_t;

endpackage

// File: rtl/calc1_if.sv
// One calculator channel: command/operand request side and response side.
interface calc1_if;

  logic [calc1_pkg::CMD_W-1:0]  cmd;
  logic [calc1_pkg::DATA_W-1:0] data;
  logic [calc1_pkg::RESP_W-1:0] resp;
  logic [calc1_pkg::DATA_W-1:0] rdata;

  modport master (output cmd, data, input resp, rdata);
  modport slave  (input cmd, data, output resp, rdata);

endinterface

// File: rtl/calc1_channel.sv
// One calculator channel: IDLE->OP2->EXEC sequencer, operand latches, ALU, output register.
// Shifts (cmds 5/6) are built only when CALC1_SHIFT_EN is defined; otherwise they answer BAD.
module calc1_channel
  import calc1_pkg::*;
(
  input  logic    c_clk,
  input  logic    reset,
  calc1_if.slave  bus
);

  localparam int unsigned SUM_W = DATA_W + 1;

  chan_state_e       state_q, state_d;
  logic [CMD_W-1:0]  cmd_q, cmd_d;
  logic [DATA_W-1:0] op1_q, op1_d;
  logic [DATA_W-1:0] op2_q, op2_d;
  resp_t             out_q, out_d;
  resp_t             alu;
  logic [SUM_W-1:0]  sum;

  // Result of the latched command; only captured while in EXEC
  always_comb begin
    alu = '0;
    sum = SUM_W'(op1_q) + SUM_W'(op2_q);
    case (cmd_q)
      ADD: begin
        if (sum[DATA_W]) begin
          alu.resp = OVF;
        end else begin
          alu.resp = OK;
          alu.data = sum[DATA_W-1:0];
        end
      end
      SUB: begin
        if (op1_q < op2_q) begin
          alu.resp = OVF;
        end else begin
          alu.resp = OK;
          alu.data = op1_q - op2_q;
        end
      end
`ifdef CALC1_SHIFT_EN
      SHL: begin
        alu.resp = OK;
        alu.data = op1_q << op2_q[SHAMT_W-1:0];
      end
      SHR: begin
        alu.resp = OK;
        alu.data = op1_q >> op2_q[SHAMT_W-1:0];
      end
`endif
      default: alu.resp = BAD;
    endcase
  end

  // Sequencer: command in IDLE, operand2 in OP2 (cmd ignored), response in EXEC
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    out_d   = '0;
    case (state_q)
      IDLE: begin
        if (bus.cmd != '0) begin
          cmd_d   = bus.cmd;
          op1_d   = bus.data;
          state_d = OP2;
        end
      end
      OP2: begin
        op2_d   = bus.data;
        state_d = EXEC;
      end
      EXEC: begin
        out_d   = alu;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cmd_q   <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      out_q   <= out_d;
    end
  end

  assign bus.resp  = out_q.resp;
  assign bus.rdata = out_q.data;

endmodule

// File: rtl/calc1_calculator.sv
// Four independent calculator channels behind flat request/response ports.
// Optional shifter per channel: define CALC1_SHIFT_EN.
module calc1_calculator
  import calc1_pkg::*;
(
  input  logic              c_clk,
  input  logic              reset,
  input  logic [CMD_W-1:0]  req1_cmd_in,
  input  logic [DATA_W-1:0] req1_data_in,
  input  logic [CMD_W-1:0]  req2_cmd_in,
  input  logic [DATA_W-1:0] req2_data_in,
  input  logic [CMD_W-1:0]  req3_cmd_in,
  input  logic [DATA_W-1:0] req3_data_in,
  input  logic [CMD_W-1:0]  req4_cmd_in,
  input  logic [DATA_W-1:0] req4_data_in,
  output logic [RESP_W-1:0] out_resp1,
  output logic [DATA_W-1:0] out_data1,
  output logic [RESP_W-1:0] out_resp2,
  output logic [DATA_W-1:0] out_data2,
  output logic [RESP_W-1:0] out_resp3,
  output logic [DATA_W-1:0] out_data3,
  output logic [RESP_W-1:0] out_resp4,
  output logic [DATA_W-1:0] out_data4
);

  calc1_if ch_if [4] ();

  assign ch_if[0].cmd  = req1_cmd_in;
  assign ch_if[0].data = req1_data_in;
  assign ch_if[1].cmd  = req2_cmd_in;
  assign ch_if[1].data = req2_data_in;
  assign ch_if[2].cmd  = req3_cmd_in;
  assign ch_if[2].data = req3_data_in;
  assign ch_if[3].cmd  = req4_cmd_in;
  assign ch_if[3].data = req4_data_in;

  assign out_resp1 = ch_if[0].resp;
  assign out_data1 = ch_if[0].rdata;
  assign out_resp2 = ch_if[1].resp;
  assign out_data2 = ch_if[1].rdata;
  assign out_resp3 = ch_if[2].resp;
  assign out_data3 = ch_if[2].rdata;
  assign out_resp4 = ch_if[3].resp;
  assign out_data4 = ch_if[3].rdata;

  for (genvar g = 0; g < 4; g++) begin : g_ch
    calc1_channel u_channel (
      .c_clk (c_clk),
      .reset (reset),
      .bus   (ch_if[g])
    );
  end

endmodule

// File: tb/tb_calc1_calculator.sv
// Randomized self-checking bench for calc1_calculator against a cycle-scheduled arithmetic model.
module tb_calc1_calculator;

  localparam int NCH = 4;

  typedef struct {
    logic [3:0]  cmd;
    logic [31:0] a;
    logic [31:0] b;
  } req_t;

  logic        c_clk = 1'b0;
  logic        reset;
  logic [3:0]  cmd_drv   [NCH];
  logic [31:0] data_drv  [NCH];
  logic [3:0]  cmd_w     [NCH];
  logic [31:0] data_w    [NCH];
  logic [1:0]  resp_w    [NCH];
  logic [31:0] rdata_w   [NCH];
  logic [1:0]  resp_obs  [NCH];
  logic [31:0] rdata_obs [NCH];

  always #5 c_clk = ~c_clk;

  for (genvar g = 0; g < NCH; g++) begin : g_bus
    calc1_if bus ();
    assign bus.cmd      = cmd_drv[g];
    assign bus.data     = data_drv[g];
    assign cmd_w[g]     = bus.cmd;
    assign data_w[g]    = bus.data;
    assign bus.resp     = resp_w[g];
    assign bus.rdata    = rdata_w[g];
    assign resp_obs[g]  = bus.resp;
    assign rdata_obs[g] = bus.rdata;
  end

  calc1_calculator dut (
    .c_clk        (c_clk),
    .reset        (reset),
    .req1_cmd_in  (cmd_w[0]),
    .req1_data_in (data_w[0]),
    .req2_cmd_in  (cmd_w[1]),
    .req2_data_in (data_w[1]),
    .req3_cmd_in  (cmd_w[2]),
    .req3_data_in (data_w[2]),
    .req4_cmd_in  (cmd_w[3]),
    .req4_data_in (data_w[3]),
    .out_resp1    (resp_w[0]),
    .out_data1    (rdata_w[0]),
    .out_resp2    (resp_w[1]),
    .out_data2    (rdata_w[1]),
    .out_resp3    (resp_w[2]),
    .out_data3    (rdata_w[2]),
    .out_resp4    (resp_w[3]),
    .out_data4    (rdata_w[3])
  );

  int          n_checks = 0;
  int          n_pass   = 0;
  int          edge_n   = 0;
  req_t        q         [NCH][$];
  int          pend_edge [NCH];
  int          free_edge [NCH];
  logic [33:0] pend_val  [NCH];
  bit          op2_due   [NCH];
  logic [31:0] op2_val   [NCH];

  always @(posedge c_clk) edge_n <= edge_n + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  // Expected {resp, data} from the command definitions, using 64-bit arithmetic
  function automatic logic [33:0] ref_calc(input logic [3:0] c, input logic [31:0] a,
                                           input logic [31:0] b);
    longint unsigned x, y;
    logic [33:0]     r;
    x = a;
    y = b;
    case (c)
      4'd0: r = '0;
      4'd1: r = (x + y > 64'hFFFF_FFFF) ? {2'b10, 32'h0} : {2'b01, 32'(x + y)};
      4'd2: r = (x < y) ? {2'b10, 32'h0} : {2'b01, 32'(x - y)};
`ifdef CALC1_SHIFT_EN
      4'd5: r = {2'b01, 32'((x << (y % 32)) & 64'hFFFF_FFFF)};
      4'd6: r = {2'b01, 32'(x >> (y % 32))};
`endif
      default: r = {2'b11, 32'h0};
    endcase
    return r;
  endfunction

  function automatic bit busy();
    for (int ch = 0; ch < NCH; ch++)
      if (q[ch].size() != 0 || op2_due[ch] || pend_edge[ch] > edge_n) return 1'b1;
    return 1'b0;
  endfunction

  task automatic clear_model();
    for (int ch = 0; ch < NCH; ch++) begin
      pend_edge[ch] = -1;
      free_edge[ch] = 0;
      op2_due[ch]   = 1'b0;
      cmd_drv[ch]   = '0;
      data_drv[ch]  = '0;
    end
  endtask

  task automatic check_outputs();
    logic [33:0] exp;
    for (int ch = 0; ch < NCH; ch++) begin
      exp = (pend_edge[ch] == edge_n) ? pend_val[ch] : 34'h0;
      check($sformatf("ch%0d_out@%0d", ch + 1, edge_n),
            {30'b0, resp_obs[ch], rdata_obs[ch]}, {30'b0, exp});
    end
  endtask

  // Inputs for the coming edge (edge_n+1)
  task automatic drive_inputs();
    req_t r;
    for (int ch = 0; ch < NCH; ch++) begin
      if (op2_due[ch]) begin
        cmd_drv[ch]  = 4'($urandom);
        data_drv[ch] = op2_val[ch];
        op2_due[ch]  = 1'b0;
      end else if (edge_n + 1 >= free_edge[ch] && q[ch].size() != 0) begin
        r = q[ch].pop_front();
        cmd_drv[ch]  = r.cmd;
        data_drv[ch] = r.a;
        if (r.cmd != 4'd0) begin
          op2_due[ch]   = 1'b1;
          op2_val[ch]   = r.b;
          pend_edge[ch] = edge_n + 3;
          pend_val[ch]  = ref_calc(r.cmd, r.a, r.b);
          free_edge[ch] = edge_n + 4;
        end
      end else begin
        cmd_drv[ch]  = (edge_n + 1 >= free_edge[ch]) ? 4'd0 : 4'($urandom);
        data_drv[ch] = $urandom;
      end
    end
  endtask

  task automatic tick();
    @(negedge c_clk);
    check_outputs();
    drive_inputs();
  endtask

  task automatic run_until_idle(input string tag);
    int guard = 0;
    while (busy() && guard < 3000) begin
      tick();
      guard++;
    end
    check({tag, "_drained"}, 64'(busy()), 64'd0);
  endtask

  task automatic push(input int ch, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    req_t r;
    r.cmd = c;
    r.a   = a;
    r.b   = b;
    q[ch].push_back(r);
  endtask

  task automatic push_random(input int ch);
    logic [3:0]  c;
    logic [31:0] a, b;
    case ($urandom_range(0, 9))
      0:       c = 4'd0;
      1, 2:    c = 4'd1;
      3, 4:    c = 4'd2;
      5:       c = 4'd5;
      6:       c = 4'd6;
      default: c = 4'($urandom);
    endcase
    case ($urandom_range(0, 2))
      0:       begin a = $urandom;                            b = $urandom;                  end
      1:       begin a = $urandom_range(0, 64);               b = $urandom_range(0, 64);     end
      default: begin a = 32'hFFFF_FFFF - $urandom_range(0, 8); b = $urandom_range(0, 10);    end
    endcase
    push(ch, c, a, b);
  endtask

  initial begin
    reset = 1'b1;
    clear_model();
    #1 reset = 1'b0;
    #2;
    for (int ch = 0; ch < NCH; ch++)
      check($sformatf("ch%0d_rst_init", ch + 1), {30'b0, resp_obs[ch], rdata_obs[ch]}, 64'd0);
    repeat (7) @(posedge c_clk);

    // Directed vectors, staggered by channel so channels start on different edges
    for (int ch = 0; ch < NCH; ch++) begin
      for (int k = 0; k < ch; k++) push(ch, 4'd0, $urandom, 32'd0);
      push(ch, 4'd0, 32'h64, 32'd0);
      push(ch, 4'd0, 32'h27, 32'd0);
      for (int k = 0; k < 8; k++) push(ch, 4'd0, $urandom, 32'd0);
      push(ch, 4'd1, 32'h64, 32'h27);
      push(ch, 4'd1, 32'hFFFF_FFFF, 32'h1);
      push(ch, 4'd1, 32'hFFFF_FFFE, 32'h1);
      push(ch, 4'd2, 32'h22, 32'h23);
      push(ch, 4'd2, 32'h5, 32'h2);
      push(ch, 4'd2, 32'h7, 32'h7);
      push(ch, 4'd5, 32'h3, 32'h2);
      push(ch, 4'd5, 32'h3, 32'h22);
      push(ch, 4'd5, 32'h8000_0001, 32'h1);
      push(ch, 4'd6, 32'hC, 32'h2);
      push(ch, 4'd6, 32'h8000_0000, 32'h1F);
      push(ch, 4'd9, 32'h1, 32'h1);
      push(ch, 4'd3, 32'h1, 32'h1);
      push(ch, 4'd15, 32'h1, 32'h1);
    end
    @(negedge c_clk);
    reset = 1'b1;
    drive_inputs();
    run_until_idle("directed");
    repeat (3) tick();

    for (int ch = 0; ch < NCH; ch++)
      for (int k = 0; k < 60; k++) push_random(ch);
    run_until_idle("random");
    repeat (3) tick();

    // Reset asserted while every channel sits in EXEC: no response may appear
    for (int ch = 0; ch < NCH; ch++) push(ch, 4'd1, 32'h64, 32'h27);
    tick();
    tick();
    @(negedge c_clk);
    check_outputs();
    reset = 1'b0;
    #1;
    clear_model();
    for (int ch = 0; ch < NCH; ch++)
      check($sformatf("ch%0d_rst_exec", ch + 1), {30'b0, resp_obs[ch], rdata_obs[ch]}, 64'd0);
    repeat (3) begin
      @(negedge c_clk);
      check_outputs();
    end
    for (int ch = 0; ch < NCH; ch++) push(ch, 4'd2, 32'h5, 32'h2);
    reset = 1'b1;
    drive_inputs();
    run_until_idle("post_reset");
    repeat (2) tick();

    // Reset asserted while a response is visible clears it without waiting for a clock
    for (int ch = 0; ch < NCH; ch++) push(ch, 4'd1, 32'h100, 32'h23);
    repeat (3) tick();
    @(negedge c_clk);
    check_outputs();
    reset = 1'b0;
    #1;
    for (int ch = 0; ch < NCH; ch++)
      check($sformatf("ch%0d_rst_async", ch + 1), {30'b0, resp_obs[ch], rdata_obs[ch]}, 64'd0);
    clear_model();
    @(negedge c_clk);
    check_outputs();
    reset = 1'b1;
    drive_inputs();
    repeat (4) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
